// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of the combinational 4-bit ALU: holds operands on the
// compute screen for a settle time, captures the BCD result, optionally runs a display pass.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned VIEW_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    input  logic        cmd_cin,
    input  logic        cmd_show,
    output logic [1:0]  alu_screen,
    output logic [2:0]  alu_opcode,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_cin,
    input  logic [11:0] alu_bcd,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [11:0] rsp_bcd,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic        rsp_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StShow,
        StResp
    } state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] ViewLast   = 8'(VIEW_CYCLES - 1);

    localparam logic [1:0] ScrOpcode  = 2'd0;
    localparam logic [1:0] ScrB       = 2'd2;
    localparam logic [1:0] ScrCompute = 2'd3;

    state_e      state_q, state_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]  view_cnt_q, view_cnt_d;
    logic        show_q, show_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic [1:0]  alu_screen_q, alu_screen_d;
    logic [2:0]  alu_opcode_q, alu_opcode_d;
    logic [3:0]  alu_a_q, alu_a_d;
    logic [3:0]  alu_b_q, alu_b_d;
    logic        alu_cin_q, alu_cin_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [11:0] rsp_bcd_q, rsp_bcd_d;
    logic        rsp_carry_q, rsp_carry_d;
    logic        rsp_overflow_q, rsp_overflow_d;
    logic        rsp_error_q, rsp_error_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            settle_cnt_q   <= '0;
            view_cnt_q     <= '0;
            show_q         <= 1'b0;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            alu_screen_q   <= ScrOpcode;
            alu_opcode_q   <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_cin_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_bcd_q      <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            view_cnt_q     <= view_cnt_d;
            show_q         <= show_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
            alu_screen_q   <= alu_screen_d;
            alu_opcode_q   <= alu_opcode_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_cin_q      <= alu_cin_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_bcd_q      <= rsp_bcd_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_error_q    <= rsp_error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        view_cnt_d     = view_cnt_q;
        show_d         = show_q;
        alu_screen_d   = alu_screen_q;
        alu_opcode_d   = alu_opcode_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_cin_d      = alu_cin_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_bcd_d      = rsp_bcd_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_error_d    = rsp_error_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_opcode_d = cmd_opcode;
                    alu_a_d      = cmd_a;
                    alu_b_d      = cmd_b;
                    alu_cin_d    = cmd_cin;
                    show_d       = cmd_show;
                    // Opcodes 6/7 never reach the ALU; answer immediately with an error.
                    if (cmd_opcode[2:1] == 2'b11) begin
                        state_d        = StResp;
                        rsp_valid_d    = 1'b1;
                        rsp_bcd_d      = '0;
                        rsp_carry_d    = 1'b0;
                        rsp_overflow_d = 1'b0;
                        rsp_error_d    = 1'b1;
                        alu_screen_d   = ScrOpcode;
                    end else begin
                        state_d      = StExec;
                        alu_screen_d = ScrCompute;
                        settle_cnt_d = '0;
                    end
                end
            end

            StExec: begin
                settle_cnt_d = settle_cnt_q + 4'd1;
                if (settle_cnt_q == SettleLast) begin
                    rsp_bcd_d      = alu_bcd;
                    rsp_carry_d    = alu_carry;
                    rsp_overflow_d = alu_overflow;
                    rsp_error_d    = alu_error;
                    if (show_q) begin
                        state_d      = StShow;
                        alu_screen_d = ScrOpcode;
                        view_cnt_d   = '0;
                    end else begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                    end
                end
            end

            StShow: begin
                if (view_cnt_q == ViewLast) begin
                    view_cnt_d = '0;
                    if (alu_screen_q == ScrB) begin
                        state_d      = StResp;
                        alu_screen_d = ScrCompute;
                        rsp_valid_d  = 1'b1;
                    end else begin
                        alu_screen_d = alu_screen_q + 2'd1;
                    end
                end else begin
                    view_cnt_d = view_cnt_q + 8'd1;
                end
            end

            StResp: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d      = StIdle;
                    rsp_valid_d  = 1'b0;
                    alu_screen_d = ScrOpcode;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered copies of the state decode keep every output flop-driven.
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign alu_screen   = alu_screen_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_cin      = alu_cin_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_bcd      = rsp_bcd_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a stand-in ALU that only produces a valid answer once its
// inputs have settled, plus a transaction-level model checked against the DUT every cycle.
module tb_alu_op_sequencer;

    localparam int S = 2;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [3:0]  cmd_a;
    logic [3:0]  cmd_b;
    logic        cmd_cin;
    logic        cmd_show;
    logic [1:0]  alu_screen;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_cin;
    logic [11:0] alu_bcd;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_bcd;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic        rsp_error;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .SETTLE_CYCLES(S),
        .VIEW_CYCLES  (V)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_cin     (cmd_cin),
        .cmd_show    (cmd_show),
        .alu_screen  (alu_screen),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_bcd     (alu_bcd),
        .alu_carry   (alu_carry),
        .alu_overflow(alu_overflow),
        .alu_error   (alu_error),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_bcd     (rsp_bcd),
        .rsp_carry   (rsp_carry),
        .rsp_overflow(rsp_overflow),
        .rsp_error   (rsp_error),
        .busy        (busy)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference ALU result packed as {error, overflow, carry, bcd}.
    function automatic logic [14:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic cin);
        int         ai, bi, v;
        logic [3:0] low;
        logic       c, o;
        ai = int'(a);
        bi = int'(b);
        c  = 1'b0;
        o  = 1'b0;
        case (op)
            3'd0: begin
                v   = ai + bi + int'(cin);
                low = 4'(v);
                c   = (v > 15);
                o   = (a[3] == b[3]) && (low[3] != a[3]);
            end
            3'd1: begin
                v   = ai - bi - int'(cin);
                low = 4'(v);
                c   = (v < 0);
                o   = (a[3] != b[3]) && (low[3] != a[3]);
                if (v < 0) v = -v;
            end
            3'd2:    v = ai * bi;
            3'd3:    v = int'(a & b);
            3'd4:    v = int'(a | b);
            3'd5:    v = int'(a ^ b);
            default: return {1'b1, 14'd0};
        endcase
        return {1'b0, o, c, to_bcd(v)};
    endfunction

    function automatic int resp_lat(input logic [2:0] op, input logic sh);
        if (op >= 3'd6) return 1;
        return sh ? (S + 3 * V + 1) : (S + 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in ALU: shows the selected view on screens 0..2; on the compute screen it
    // returns garbage until its inputs have been stable long enough.
    logic [13:0] cur_vec, prev_vec;
    int          stable_cnt = 0;
    logic        settled;
    logic [14:0] fa_r;

    assign cur_vec = {alu_screen, alu_opcode, alu_a, alu_b, alu_cin};
    assign settled = (cur_vec == prev_vec) && (stable_cnt + 2 >= S);

    always @(posedge clk) begin
        prev_vec <= cur_vec;
        if (cur_vec != prev_vec) stable_cnt <= 0;
        else if (stable_cnt < 1000) stable_cnt <= stable_cnt + 1;
    end

    always_comb begin
        fa_r         = alu_ref(alu_opcode, alu_a, alu_b, alu_cin);
        alu_bcd      = 12'hFFF;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        alu_error    = 1'b1;
        if (alu_screen != 2'd3) begin
            alu_carry    = 1'b0;
            alu_overflow = 1'b0;
            alu_error    = 1'b0;
            if (alu_screen == 2'd0) alu_bcd = to_bcd(int'(alu_opcode));
            else if (alu_screen == 2'd1) alu_bcd = to_bcd(int'(alu_a));
            else alu_bcd = to_bcd(int'(alu_b));
        end else if (settled) begin
            alu_bcd      = fa_r[11:0];
            alu_carry    = fa_r[12];
            alu_overflow = fa_r[13];
            alu_error    = fa_r[14];
        end
    end

    // Transaction model: idle, or busy for m_k cycles since the accept edge.
    bit          started = 1'b0;
    bit          m_busy;
    int          m_k;
    logic [2:0]  m_op;
    logic [3:0]  m_a, m_b;
    logic        m_cin, m_show;
    logic [14:0] m_old, m_new;

    always @(posedge clk) begin
        if (rst) begin
            started <= 1'b1;
            m_busy  <= 1'b0;
            m_k     <= 0;
            m_op    <= '0;
            m_a     <= '0;
            m_b     <= '0;
            m_cin   <= 1'b0;
            m_show  <= 1'b0;
            m_old   <= '0;
            m_new   <= '0;
        end else if (started) begin
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy <= 1'b1;
                    m_k    <= 1;
                    m_op   <= cmd_opcode;
                    m_a    <= cmd_a;
                    m_b    <= cmd_b;
                    m_cin  <= cmd_cin;
                    m_show <= cmd_show;
                    m_old  <= m_new;
                    m_new  <= alu_ref(cmd_opcode, cmd_a, cmd_b, cmd_cin);
                end
            end else if (m_k >= resp_lat(m_op, m_show) && rsp_ready) begin
                m_busy <= 1'b0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp_p
        logic [14:0] e_rsp;
        logic [1:0]  e_scr;
        logic        e_valid;
        int          cap_k;
        if (started) begin
            cap_k = (m_op >= 3'd6) ? 1 : S + 1;
            if (m_busy) begin
                e_valid = (m_k >= resp_lat(m_op, m_show));
                e_rsp   = (m_k >= cap_k) ? m_new : m_old;
                if (m_op >= 3'd6) e_scr = 2'd0;
                else if (m_show && m_k >= S + 1 && m_k <= S + 3 * V) e_scr = 2'((m_k - S - 1) / V);
                else e_scr = 2'd3;
            end else begin
                e_valid = 1'b0;
                e_rsp   = m_new;
                e_scr   = 2'd0;
            end
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, e_valid);
            chk("alu_screen", alu_screen, e_scr);
            chk("alu_opcode", alu_opcode, m_op);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_cin", alu_cin, m_cin);
            chk("rsp_bcd", rsp_bcd, e_rsp[11:0]);
            chk("rsp_carry", rsp_carry, e_rsp[12]);
            chk("rsp_overflow", rsp_overflow, e_rsp[13]);
            chk("rsp_error", rsp_error, e_rsp[14]);
        end
    end

    task automatic scramble_cmd();
        cmd_opcode = 3'($urandom);
        cmd_a      = 4'($urandom);
        cmd_b      = 4'($urandom);
        cmd_cin    = 1'($urandom);
        cmd_show   = 1'($urandom);
    endtask

    // Called at a negedge; returns at a negedge one cycle after the response handshake.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic cin, input logic show, input int hold, input bit pulse,
                           output int lat, output logic [14:0] r);
        int n;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_cin    = cin;
        cmd_show   = show;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        scramble_cmd();
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp arrives", rsp_valid, 1);
        r = {rsp_error, rsp_overflow, rsp_carry, rsp_bcd};
        for (int i = 0; i < hold; i++) begin
            cmd_valid = pulse && (i == 0);
            scramble_cmd();
            @(negedge clk);
            chk("hold rsp_valid", rsp_valid, 1);
            chk("hold rsp_bcd", rsp_bcd, r[11:0]);
            chk("hold cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("cmd_ready after handshake", cmd_ready, 1);
        chk("rsp_valid after handshake", rsp_valid, 0);
    endtask

    initial begin
        int          lat;
        logic [14:0] r;
        logic [2:0]  op;
        logic        sh;
        int          hold;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        scramble_cmd();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset alu_screen", alu_screen, 0);

        run_cmd(3'd0, 4'd5, 4'd7, 1'b0, 1'b0, 0, 1'b0, lat, r);
        chk("add latency", lat, 3);
        chk("add bcd", r[11:0], 12'h012);
        chk("add carry", r[12], 0);
        chk("add error", r[14], 0);

        run_cmd(3'd2, 4'd15, 4'd15, 1'b0, 1'b0, 2, 1'b0, lat, r);
        chk("mul latency", lat, 3);
        chk("mul bcd", r[11:0], 12'h225);
        chk("mul carry", r[12], 0);

        run_cmd(3'd6, 4'd3, 4'd3, 1'b0, 1'b0, 0, 1'b0, lat, r);
        chk("illegal latency", lat, 1);
        chk("illegal bcd", r[11:0], 12'h000);
        chk("illegal error", r[14], 1);

        run_cmd(3'd1, 4'd9, 4'd3, 1'b0, 1'b1, 0, 1'b0, lat, r);
        chk("show latency", lat, 15);
        chk("show bcd", r[11:0], 12'h006);

        run_cmd(3'd0, 4'd2, 4'd3, 1'b0, 1'b0, 5, 1'b1, lat, r);
        chk("backpressure latency", lat, 3);
        chk("backpressure bcd", r[11:0], 12'h005);

        // Abort in the second compute cycle.
        cmd_valid  = 1'b1;
        cmd_opcode = 3'd0;
        cmd_a      = 4'd4;
        cmd_b      = 4'd4;
        cmd_cin    = 1'b0;
        cmd_show   = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort cmd_ready", cmd_ready, 1);
        chk("abort rsp_valid", rsp_valid, 0);
        chk("abort alu_a", alu_a, 0);
        chk("abort alu_screen", alu_screen, 0);
        chk("abort rsp_bcd", rsp_bcd, 0);

        run_cmd(3'd0, 4'd1, 4'd1, 1'b0, 1'b0, 0, 1'b0, lat, r);
        chk("post-abort latency", lat, 3);
        chk("post-abort bcd", r[11:0], 12'h002);

        for (int i = 0; i < 150; i++) begin
            op   = 3'($urandom_range(0, 7));
            sh   = ($urandom_range(0, 2) == 0);
            hold = $urandom_range(0, 3);
            run_cmd(op, 4'($urandom), 4'($urandom), 1'($urandom), sh, hold,
                    (hold >= 2) && ($urandom_range(0, 1) == 1), lat, r);
            chk("random latency", lat, resp_lat(op, sh));
            if ($urandom_range(0, 3) == 0) begin
                scramble_cmd();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Synchronous command sequencer in front of the combinational 4-bit ALU top level. It accepts one operation at a time over a valid/ready command port and drives the ALU operand, opcode, carry and screen-select inputs. It waits a fixed settle time, then captures the ALU's BCD result and flags, and returns them over a valid/ready response port. An optional display pass steps the screen select through opcode, A and B views before the response is returned.

Parameters:
SETTLE_CYCLES, 2, cycles the ALU inputs are held on compute screen (3) before capture; legal range 1..15.
VIEW_CYCLES, 4, dwell cycles per screen during the display pass; legal range 1..255.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_opcode  input  3  ALU opcode: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6-7 illegal
cmd_a  input  4  operand A
cmd_b  input  4  operand B
cmd_cin  input  1  carry/borrow in
cmd_show  input  1  run the display pass for this command
alu_screen  output  2  ALU screen select: 0 opcode, 1 A, 2 B, 3 compute
alu_opcode  output  3  to ALU opcode pins
alu_a  output  4  to ALU A pins
alu_b  output  4  to ALU B pins
alu_cin  output  1  to ALU carry_in
alu_bcd  input  12  {h,t,o} BCD digits from the ALU
alu_carry  input  1  ALU carry_out_output
alu_overflow  input  1  ALU overflow
alu_error  input  1  ALU error
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_bcd  output  12  captured {h,t,o}
rsp_carry  output  1  captured carry/borrow
rsp_overflow  output  1  captured overflow
rsp_error  output  1  illegal opcode flag
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE; cmd_ready 1; rsp_valid 0; busy 0; alu_screen 0; alu_opcode, alu_a, alu_b, alu_cin 0; rsp_bcd 0; rsp_carry, rsp_overflow, rsp_error 0; counters 0.
- A reset asserted in any state, including mid-EXEC or mid-SHOW, aborts the operation with no response, and all values above apply the next cycle.
- Registered outputs: all outputs are registered. cmd_ready = (state == IDLE).
- IDLE: cmd_valid & cmd_ready latches opcode, A, B, cin and show into the alu_* output registers and an internal show flag.
  - Opcode 6 or 7 goes to RESP with rsp_error 1, rsp_bcd 0, rsp_carry 0 and rsp_overflow 0. The ALU is not exercised and alu_screen stays 0.
  - Any other opcode goes to EXEC with alu_screen 3 and the settle counter at 0.
- EXEC: the counter increments each cycle. In the cycle where the counter equals SETTLE_CYCLES-1, the sequencer captures alu_bcd, alu_carry and alu_overflow into the rsp_* registers and sets rsp_error to alu_error.
  - Next state is SHOW if the show flag is set, otherwise RESP.
  - Latency: with show clear, rsp_valid rises SETTLE_CYCLES+1 cycles after the accept edge.
- SHOW: alu_screen is 0, then 1, then 2, each held exactly VIEW_CYCLES cycles.
  - Captured rsp_* values are not altered while SHOW runs.
  - After screen 2 expires, alu_screen returns to 3 and the state goes to RESP.
  - This adds 3*VIEW_CYCLES cycles of latency.
- RESP: rsp_valid is 1 and rsp_* are stable until the sequencer sees rsp_valid & rsp_ready.
  - On that handshake: rsp_valid 0, alu_screen 0, state IDLE.
  - cmd_ready rises the cycle after the handshake; there is no same-cycle turnaround.
- Command port: cmd_* inputs are ignored outside IDLE. The upstream source holds cmd_valid and its data until cmd_ready is sampled high.
- Operand stability: alu_opcode, alu_a, alu_b and alu_cin are held constant from accept until the RESP handshake.
- Counter widths: the settle counter is 4 bits and the view counter is 8 bits. Neither counter can wrap within the legal parameter range.

Test Plan:
- Add: opcode 0, A=5, B=7, cin=0, show=0, SETTLE_CYCLES=2, ALU model returns 0x012 → rsp_valid rises 3 cycles after accept; rsp_bcd 0x012, carry 0, error 0; alu_screen 3 during EXEC.
- Multiply: opcode 2, A=15, B=15 → rsp_bcd 0x225, carry 0; operands stay stable until the handshake.
- Illegal opcode: opcode 6, A=3, B=3 → rsp_valid 1 cycle after accept, rsp_error 1, rsp_bcd 0x000, alu_screen never 3.
- Display pass: opcode 1, A=9, B=3, show=1, VIEW_CYCLES=4 → alu_screen sequence 3,3,0×4,1×4,2×4,3; rsp_bcd 0x006; rsp_valid rises 15 cycles after accept.
- Backpressure: hold rsp_ready low 5 cycles → rsp_valid and rsp_bcd held constant, cmd_ready 0, and a cmd_valid pulse during RESP is ignored; cmd_ready rises 1 cycle after rsp_ready goes high.
- Reset mid-operation: assert rst in the second EXEC cycle → next cycle IDLE, cmd_ready 1, rsp_valid 0, all alu_* 0; a follow-up add 1+1 returns 0x002 normally.
